// File: rtl/pulse_train_generator.sv
// Pulse train generator: emits N pulses of W high cycles separated by G low cycles,
// then a one-cycle done strobe. All outputs are registered.
module pulse_train_generator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] width_eff;
  logic [CNT_W-1:0] gap_eff;

  // Zero-length phases are promoted to one cycle so every pulse is visible.
  assign width_eff = (width == '0) ? One : width;
  assign gap_eff   = (gap == '0) ? One : gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      width_q   <= '0;
      gap_q     <= '0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          state <= StIdle;
          pulse <= 1'b0;
          busy  <= 1'b0;
          if (start && !abort) begin
            width_q   <= width_eff;
            gap_q     <= gap_eff;
            pulse_cnt <= count;
            if (count == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state     <= StHigh;
              phase_cnt <= width_eff;
              pulse     <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        StHigh: begin
          if (abort) begin
            state     <= StIdle;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            phase_cnt <= '0;
            pulse_cnt <= '0;
          end else if (phase_cnt == One) begin
            pulse <= 1'b0;
            if (pulse_cnt == One) begin
              // Last pulse: no trailing gap.
              state     <= StDone;
              busy      <= 1'b0;
              done      <= 1'b1;
              phase_cnt <= '0;
              pulse_cnt <= '0;
            end else begin
              state     <= StLow;
              phase_cnt <= gap_q;
              pulse_cnt <= pulse_cnt - One;
            end
          end else begin
            phase_cnt <= phase_cnt - One;
          end
        end
        StLow: begin
          if (abort) begin
            state     <= StIdle;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            phase_cnt <= '0;
            pulse_cnt <= '0;
          end else if (phase_cnt == One) begin
            state     <= StHigh;
            phase_cnt <= width_q;
            pulse     <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - One;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator using a per-cycle expected-output queue
// built from the train rules (W high, G low, N pulses, one done cycle).
module tb_pulse_train_generator;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] count;
  logic             pulse;
  logic             busy;
  logic             done;

  int total;
  int bad;

  // Each entry is {pulse, busy, done} expected for one cycle.
  logic [2:0] exp_q[$];
  logic [2:0] obs;

  pulse_train_generator #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .width(width),
    .gap  (gap),
    .count(count),
    .pulse(pulse),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_train(input int w, input int g, input int n);
    int we;
    int ge;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    for (int p = 0; p < n; p++) begin
      repeat (we) exp_q.push_back(3'b110);
      if (p < n - 1) repeat (ge) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic drive_start(input int w, input int g, input int n);
    start = 1'b1;
    width = CNT_W'(w);
    gap   = CNT_W'(g);
    count = CNT_W'(n);
  endtask

  task automatic scramble;
    width = CNT_W'($urandom_range(0, 255));
    gap   = CNT_W'($urandom_range(0, 255));
    count = CNT_W'($urandom_range(0, 255));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    width = 8'd1;
    gap   = 8'd1;
    count = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {pulse, busy, done};
      total++;
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL reset cyc %0d pbd=%b required 000", i, obs);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    obs = {pulse, busy, done};
    total++;
    if (obs !== 3'b000) begin
      bad++;
      $display("FAIL reset_release pbd=%b required 000", obs);
    end
  endtask

  task automatic test_trains;
    int tw[7] = '{1, 2, 0, 0, 255, 1, 1};
    int tg[7] = '{1, 3, 5, 0, 1, 1, 255};
    int tn[7] = '{3, 2, 0, 2, 2, 255, 1};
    int w, g, n;
    for (int t = 0; t < 19; t++) begin
      if (t < 7) begin
        w = tw[t]; g = tg[t]; n = tn[t];
      end else begin
        w = $urandom_range(0, 6); g = $urandom_range(0, 6); n = $urandom_range(0, 5);
      end
      exp_q.delete();
      model_train(w, g, n);
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b000);
      @(negedge clk);
      drive_start(w, g, n);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        obs = {pulse, busy, done};
        total++;
        if (obs !== exp_q[i]) begin
          bad++;
          $display("FAIL train%0d(w=%0d g=%0d n=%0d) cyc %0d pbd=%b required %b",
                   t, w, g, n, i + 1, obs, exp_q[i]);
        end
        // Starts while busy must be ignored; parameter changes must not leak in.
        start = exp_q[i][1] && ($urandom_range(0, 1) == 1);
        scramble();
      end
      start = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int len_a;
    int w, g, n;
    exp_q.delete();
    model_train(1, 1, 2);
    model_train(1, 1, 2);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b000);
    @(negedge clk);
    drive_start(1, 1, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = {pulse, busy, done};
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_held cyc %0d pbd=%b required %b", i + 1, obs, exp_q[i]);
      end
      start = (i <= 3);
    end
    for (int t = 0; t < 4; t++) begin
      w = $urandom_range(0, 4); g = $urandom_range(0, 4); n = $urandom_range(1, 4);
      exp_q.delete();
      model_train(w, g, n);
      len_a = exp_q.size();
      model_train(g, w, n + 1);
      exp_q.push_back(3'b000);
      @(negedge clk);
      drive_start(w, g, n);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        obs = {pulse, busy, done};
        total++;
        if (obs !== exp_q[i]) begin
          bad++;
          $display("FAIL b2b%0d cyc %0d pbd=%b required %b", t, i + 1, obs, exp_q[i]);
        end
        if (i == len_a - 1) drive_start(g, w, n + 1);
        else begin
          start = 1'b0;
          scramble();
        end
      end
    end
  endtask

  task automatic test_abort;
    exp_q.delete();
    model_train(4, 2, 3);
    @(negedge clk);
    drive_start(4, 2, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {pulse, busy, done};
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL abort_pre cyc %0d pbd=%b required %b", i + 1, obs, exp_q[i]);
      end
      start = 1'b0;
      if (i == 7) abort = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      abort = 1'b0;
      obs = {pulse, busy, done};
      total++;
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL abort_post cyc %0d pbd=%b required 000", i, obs);
      end
    end
    exp_q.delete();
    model_train(3, 1, 2);
    exp_q.push_back(3'b000);
    drive_start(3, 1, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = {pulse, busy, done};
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL abort_restart cyc %0d pbd=%b required %b", i + 1, obs, exp_q[i]);
      end
      start = 1'b0;
    end
    // Abort wins over a simultaneous start while idle.
    drive_start(2, 2, 2);
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {pulse, busy, done};
      total++;
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL abort_vs_start cyc %0d pbd=%b required 000", i, obs);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_midtrain_reset;
    @(negedge clk);
    drive_start(6, 2, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      obs = {pulse, busy, done};
      total++;
      if (obs !== 3'b110) begin
        bad++;
        $display("FAIL rst_pre cyc %0d pbd=%b required 110", i + 1, obs);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {pulse, busy, done};
    total++;
    if (obs !== 3'b000) begin
      bad++;
      $display("FAIL rst_async pbd=%b required 000 before next edge", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = {pulse, busy, done};
      total++;
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL rst_after cyc %0d pbd=%b required 000", i, obs);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_trains();
    test_back_to_back();
    test_abort();
    test_midtrain_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
